ann_run_controller: RTL and testbench
=====================================

ANN_RUN_CONTROLLER -- requirements
Module: ann_run_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 10000, WAIT-state cycle limit before a run is aborted as timed out.
REQ-002 Parameter CNT_W, default 16, width of the cycle counter and resp_cycles; TIMEOUT_CYCLES SHALL be < 2^CNT_W.
REQ-003 clock  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 req_valid  in  1  host requests one inference run.
REQ-006 req_ready  out  1  controller can accept a request.
REQ-007 acc_start  out  1  start pulse to the accelerator's start_port.
REQ-008 acc_done  in  1  accelerator done_port.
REQ-009 acc_result  in  32  accelerator return_port (predicted label).
REQ-010 resp_valid  out  1  run result available.
REQ-011 resp_ready  in  1  host accepts the result.
REQ-012 resp_label  out  32  captured label; 0xFFFFFFFF on timeout.
REQ-013 resp_timeout  out  1  result is a timeout abort.
REQ-014 resp_cycles  out  CNT_W  WAIT cycles until done or timeout.
REQ-015 busy  out  1  high in START and WAIT.
REQ-016 spurious_done  out  1  sticky flag: acc_done seen outside WAIT.

Function
REQ-017 FSM states: IDLE, START, WAIT, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; resp_valid SHALL be 1 only in RESP.
REQ-019 IDLE -> START on the cycle req_valid=1 (request accepted at that edge).
REQ-020 START lasts exactly one cycle with acc_start=1; acc_start SHALL be 0 in every other state.
REQ-021 START -> WAIT unconditionally; cycle counter loaded to 1 on entry to WAIT.
REQ-022 In WAIT, counter increments by 1 per cycle while acc_done=0.
REQ-023 WAIT with acc_done=1: resp_label<=acc_result, resp_cycles<=counter, resp_timeout<=0, -> RESP.
REQ-024 WAIT with acc_done=0 and counter=TIMEOUT_CYCLES: resp_label<=0xFFFFFFFF, resp_cycles<=TIMEOUT_CYCLES, resp_timeout<=1, -> RESP.
REQ-025 acc_done=1 in the same cycle as the timeout condition: done wins, REQ-023 applies.
REQ-026 RESP holds resp_label/resp_cycles/resp_timeout stable until resp_valid&&resp_ready, then -> IDLE.
REQ-027 Request-to-start latency: acc_start high exactly 1 cycle after the accepting edge; resp_valid high 1 cycle after the edge sampling acc_done.
REQ-028 resp_* registers retain last values in IDLE/START/WAIT until overwritten by the next capture.
REQ-029 req_valid in START/WAIT/RESP SHALL be ignored (not queued).
REQ-030 acc_done=1 in IDLE, START or RESP SHALL not change state or resp_* and SHALL set spurious_done.
REQ-031 spurious_done clears only by reset.
REQ-032 Counter SHALL never wrap; it saturates at TIMEOUT_CYCLES by construction of REQ-024.

Reset
REQ-033 reset=0 at a rising edge: state<=IDLE, acc_start=0, busy=0, resp_valid=0, resp_label=0, resp_timeout=0, resp_cycles=0, counter=0, spurious_done=0.
REQ-034 Reset asserted mid-run (START/WAIT/RESP) SHALL abort immediately with REQ-033 values; a later acc_done from the aborted run is treated per REQ-030.
REQ-035 During reset req_ready=0; req_ready=1 from the first edge after reset deasserts.

Verification
REQ-036 Normal run: reset low 5 cycles, req_valid 1 cycle, model asserts acc_done with acc_result=7 on WAIT cycle 700 -> acc_start one 1-cycle pulse, resp_label=7, resp_cycles=700, resp_timeout=0.
REQ-037 Timeout: TIMEOUT_CYCLES=50, acc_done never -> resp_valid after 50 WAIT cycles, resp_label=0xFFFFFFFF, resp_timeout=1, resp_cycles=50.
REQ-038 Tie: TIMEOUT_CYCLES=50, acc_done=1 with acc_result=3 on WAIT cycle 50 -> resp_label=3, resp_timeout=0, resp_cycles=50.
REQ-039 Backpressure: resp_ready=0 for 20 cycles in RESP, req_valid held 1 -> outputs stable, no second acc_start, IDLE then new run after handshake.
REQ-040 Spurious/reset: acc_done pulse in IDLE -> spurious_done=1, state IDLE; reset mid-WAIT -> all REQ-033 values next edge, spurious_done=0.

Source files
------------

// File: rtl/ann_run_controller.sv
// ann_run_controller: host-side handshake wrapper that starts one accelerator run, waits for done or timeout, and holds the result.
module ann_run_controller #(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    output logic             acc_start,
    input  logic             acc_done,
    input  logic [31:0]      acc_result,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_label,
    output logic             resp_timeout,
    output logic [CNT_W-1:0] resp_cycles,
    output logic             busy,
    output logic             spurious_done
);
    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
    state_t           state;
    logic [CNT_W-1:0] counter;
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            req_ready     <= 1'b0;
            acc_start     <= 1'b0;
            busy          <= 1'b0;
            resp_valid    <= 1'b0;
            resp_label    <= '0;
            resp_timeout  <= 1'b0;
            resp_cycles   <= '0;
            counter       <= '0;
            spurious_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // req_ready comes up one edge after reset, so acceptance needs it already high
                    if (req_valid && req_ready) begin
                        state     <= START;
                        req_ready <= 1'b0;
                        acc_start <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                START: begin
                    state     <= WAIT;
                    acc_start <= 1'b0;
                    counter   <= CNT_W'(1);
                end
                WAIT: begin
                    if (acc_done || counter == LIMIT) begin
                        state        <= RESP;
                        busy         <= 1'b0;
                        resp_valid   <= 1'b1;
                        resp_label   <= acc_done ? acc_result : 32'hFFFF_FFFF;
                        resp_timeout <= !acc_done;
                        resp_cycles  <= counter;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (acc_done && state != WAIT) spurious_done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ann_run_controller.sv
// tb_ann_run_controller: directed table plus hand-written sequences for run, timeout, tie, backpressure and reset corners.
module tb_ann_run_controller;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rv_a = 1'b0, dn_a = 1'b0, rr_a = 1'b0;
    logic [31:0] res_a = '0;
    logic        req_ready_a, acc_start_a, resp_valid_a, resp_timeout_a, busy_a, sp_a;
    logic [31:0] label_a;
    logic [15:0] cyc_a;
    logic        rv_b = 1'b0, dn_b = 1'b0, rr_b = 1'b0;
    logic [31:0] res_b = '0;
    logic        req_ready_b, acc_start_b, resp_valid_b, resp_timeout_b, busy_b, sp_b;
    logic [31:0] label_b;
    logic [15:0] cyc_b;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clock = ~clock;

    ann_run_controller u_a (
        .clock(clock), .reset(reset), .req_valid(rv_a), .req_ready(req_ready_a),
        .acc_start(acc_start_a), .acc_done(dn_a), .acc_result(res_a),
        .resp_valid(resp_valid_a), .resp_ready(rr_a), .resp_label(label_a),
        .resp_timeout(resp_timeout_a), .resp_cycles(cyc_a), .busy(busy_a),
        .spurious_done(sp_a)
    );

    ann_run_controller #(.TIMEOUT_CYCLES(50)) u_b (
        .clock(clock), .reset(reset), .req_valid(rv_b), .req_ready(req_ready_b),
        .acc_start(acc_start_b), .acc_done(dn_b), .acc_result(res_b),
        .resp_valid(resp_valid_b), .resp_ready(rr_b), .resp_label(label_b),
        .resp_timeout(resp_timeout_b), .resp_cycles(cyc_b), .busy(busy_b),
        .spurious_done(sp_b)
    );

    typedef struct {
        logic        rv, dn;
        logic [31:0] res;
        logic        rr;
        logic        e_rr, e_as, e_busy, e_rv;
        logic [31:0] e_lab;
        logic        e_to;
        logic [15:0] e_cyc;
        logic        e_sp;
    } vec_t;

    vec_t tbl[11];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_b_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready_b, 0);
        chk({tag, "_acc_start"}, acc_start_b, 0);
        chk({tag, "_busy"}, busy_b, 0);
        chk({tag, "_resp_valid"}, resp_valid_b, 0);
        chk({tag, "_label"}, label_b, 0);
        chk({tag, "_timeout"}, resp_timeout_b, 0);
        chk({tag, "_cycles"}, cyc_b, 0);
        chk({tag, "_spurious"}, sp_b, 0);
    endtask

    initial begin
        int starts;
        int unstable;
        // rv dn res rr | req_ready acc_start busy resp_valid label timeout cycles spurious
        tbl[0]  = '{1, 0, 32'h0,  0, 0, 1, 1, 0, 32'h0,  0, 16'd0, 0};
        tbl[1]  = '{1, 0, 32'h0,  0, 0, 0, 1, 0, 32'h0,  0, 16'd0, 0};
        tbl[2]  = '{0, 0, 32'h0,  0, 0, 0, 1, 0, 32'h0,  0, 16'd0, 0};
        tbl[3]  = '{0, 1, 32'h55, 0, 0, 0, 0, 1, 32'h55, 0, 16'd2, 0};
        tbl[4]  = '{1, 1, 32'h66, 0, 0, 0, 0, 1, 32'h55, 0, 16'd2, 1};
        tbl[5]  = '{0, 0, 32'h0,  1, 1, 0, 0, 0, 32'h55, 0, 16'd2, 1};
        tbl[6]  = '{0, 0, 32'h0,  0, 1, 0, 0, 0, 32'h55, 0, 16'd2, 1};
        tbl[7]  = '{1, 0, 32'h0,  0, 0, 1, 1, 0, 32'h55, 0, 16'd2, 1};
        tbl[8]  = '{0, 1, 32'h77, 0, 0, 0, 1, 0, 32'h55, 0, 16'd2, 1};
        tbl[9]  = '{0, 1, 32'h9,  0, 0, 0, 0, 1, 32'h9,  0, 16'd1, 1};
        tbl[10] = '{0, 0, 32'h0,  1, 1, 0, 0, 0, 32'h9,  0, 16'd1, 1};

        #1;
        for (int i = 0; i < 5; i++) tick();
        chk_b_zero("reset");
        chk("reset_req_ready_a", req_ready_a, 0);
        reset = 1'b1;
        tick();
        chk("post_reset_req_ready_b", req_ready_b, 1);
        chk("post_reset_req_ready_a", req_ready_a, 1);

        for (int i = 0; i < 11; i++) begin
            rv_b = tbl[i].rv; dn_b = tbl[i].dn; res_b = tbl[i].res; rr_b = tbl[i].rr;
            tick();
            chk($sformatf("v%0d_req_ready", i), req_ready_b, tbl[i].e_rr);
            chk($sformatf("v%0d_acc_start", i), acc_start_b, tbl[i].e_as);
            chk($sformatf("v%0d_busy", i), busy_b, tbl[i].e_busy);
            chk($sformatf("v%0d_resp_valid", i), resp_valid_b, tbl[i].e_rv);
            chk($sformatf("v%0d_label", i), label_b, tbl[i].e_lab);
            chk($sformatf("v%0d_timeout", i), resp_timeout_b, tbl[i].e_to);
            chk($sformatf("v%0d_cycles", i), cyc_b, tbl[i].e_cyc);
            chk($sformatf("v%0d_spurious", i), sp_b, tbl[i].e_sp);
        end
        rv_b = 0; dn_b = 0; rr_b = 0; res_b = 0;

        // normal run, done on WAIT cycle 700
        rv_a = 1;
        tick();
        chk("run_acc_start", acc_start_a, 1);
        rv_a = 0;
        starts = 0;
        tick();
        for (int k = 1; k < 700; k++) begin
            starts += int'(acc_start_a);
            tick();
        end
        starts += int'(acc_start_a);
        chk("run_busy_wait", busy_a, 1);
        dn_a = 1; res_a = 32'd7;
        tick();
        dn_a = 0; res_a = 0;
        chk("run_extra_starts", starts, 0);
        chk("run_resp_valid", resp_valid_a, 1);
        chk("run_label", label_a, 7);
        chk("run_cycles", cyc_a, 700);
        chk("run_timeout", resp_timeout_a, 0);
        rr_a = 1;
        tick();
        rr_a = 0;
        chk("run_back_idle", req_ready_a, 1);

        // timeout after 50 WAIT cycles
        rv_b = 1;
        tick();
        rv_b = 0;
        tick();
        for (int k = 1; k < 50; k++) tick();
        chk("to_not_early", resp_valid_b, 0);
        tick();
        chk("to_resp_valid", resp_valid_b, 1);
        chk("to_label", label_b, 32'hFFFF_FFFF);
        chk("to_timeout", resp_timeout_b, 1);
        chk("to_cycles", cyc_b, 50);
        chk("to_busy", busy_b, 0);
        rr_b = 1;
        tick();
        rr_b = 0;

        // done on the timeout cycle wins
        rv_b = 1;
        tick();
        rv_b = 0;
        tick();
        for (int k = 1; k < 50; k++) tick();
        dn_b = 1; res_b = 32'd3;
        tick();
        dn_b = 0; res_b = 0;
        chk("tie_resp_valid", resp_valid_b, 1);
        chk("tie_label", label_b, 3);
        chk("tie_timeout", resp_timeout_b, 0);
        chk("tie_cycles", cyc_b, 50);
        rr_b = 1;
        tick();
        rr_b = 0;

        // backpressure with req_valid held high
        rv_b = 1;
        tick();
        rv_b = 0;
        tick();
        for (int k = 1; k < 5; k++) tick();
        dn_b = 1; res_b = 32'hA5;
        tick();
        dn_b = 0; res_b = 0;
        rv_b = 1;
        starts = 0;
        unstable = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            starts += int'(acc_start_b);
            if (!resp_valid_b || label_b !== 32'hA5 || cyc_b !== 16'd5 || resp_timeout_b !== 1'b0 || req_ready_b)
                unstable++;
        end
        chk("bp_unstable", unstable, 0);
        chk("bp_starts", starts, 0);
        chk("bp_label", label_b, 32'hA5);
        chk("bp_cycles", cyc_b, 5);
        rr_b = 1;
        tick();
        rr_b = 0;
        chk("bp_idle_ready", req_ready_b, 1);
        chk("bp_idle_valid", resp_valid_b, 0);
        tick();
        chk("bp_new_start", acc_start_b, 1);
        rv_b = 0;
        tick();
        dn_b = 1; res_b = 32'h11;
        tick();
        dn_b = 0; res_b = 0;
        chk("bp_new_label", label_b, 32'h11);
        chk("bp_new_cycles", cyc_b, 1);
        rr_b = 1;
        tick();
        rr_b = 0;

        // spurious done in IDLE, then reset mid-WAIT
        reset = 0;
        tick();
        reset = 1;
        tick();
        chk("sp_clear", sp_b, 0);
        dn_b = 1;
        tick();
        dn_b = 0;
        chk("sp_set", sp_b, 1);
        chk("sp_idle", req_ready_b, 1);
        chk("sp_no_resp", resp_valid_b, 0);
        rv_b = 1;
        tick();
        rv_b = 0;
        tick();
        tick();
        chk("mid_busy", busy_b, 1);
        reset = 0;
        tick();
        chk_b_zero("mid_reset");
        reset = 1;
        dn_b = 1; res_b = 32'h44;
        tick();
        dn_b = 0; res_b = 0;
        chk("late_done_sp", sp_b, 1);
        chk("late_done_idle", req_ready_b, 1);
        chk("late_done_label", label_b, 0);
        chk("late_done_valid", resp_valid_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
